// File: rtl/descrypt_key_sched_if.sv
// Handshake bundle between the PC-1 stage, the key-schedule stage and the
// round-function pipeline. The slave modport is the key-schedule view; the
// master modport is the surrounding (upstream + downstream) view.
// Optional macro DESCRYPT_KS_DECRYPT_EN adds the dec select line.
interface descrypt_key_sched_if;
  logic [55:0] cd_in;
  logic        cd_valid;
  logic        cd_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round;
  logic        last_round;
  logic        last_iter;
`ifdef DESCRYPT_KS_DECRYPT_EN
  logic        dec;

  modport slave (
    input  cd_in, cd_valid, subkey_ready, dec,
    output cd_ready, subkey, subkey_valid, round, last_round, last_iter
  );

  modport master (
    output cd_in, cd_valid, subkey_ready, dec,
    input  cd_ready, subkey, subkey_valid, round, last_round, last_iter
  );
`else
  modport slave (
    input  cd_in, cd_valid, subkey_ready,
    output cd_ready, subkey, subkey_valid, round, last_round, last_iter
  );

  modport master (
    output cd_in, cd_valid, subkey_ready,
    input  cd_ready, subkey, subkey_valid, round, last_round, last_iter
  );
`endif
endinterface

// File: rtl/descrypt_key_sched.sv
// Sequential DES key schedule for the descrypt core.
// Takes one 56-bit C||D word (PC-1 output), then emits the 16 PC-2 round
// subkeys one per handshake, repeating the full 16-key pass ITERATIONS times.
// Optional macro DESCRYPT_KS_DECRYPT_EN: adds a dec input (sampled at load)
// that produces the subkeys in reverse order K16..K1 using right rotations.
module descrypt_key_sched #(
  parameter int ITERATIONS = 25
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  descrypt_key_sched_if.slave   ks
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [5:0] ITER_LAST = 6'(ITERATIONS - 1);

  // PC-2 selection table: entry i gives the C||D bit (1 = MSB) feeding
  // subkey bit i+1 (subkey bit 1 = MSB).
  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  state_t      state_q, state_d;
  logic [27:0] c_half_q, c_half_d;
  logic [27:0] d_half_q, d_half_d;
  logic [47:0] subkey_q, subkey_d;
  logic [3:0]  round_q, round_d;
  logic [5:0]  iter_q, iter_d;
`ifdef DESCRYPT_KS_DECRYPT_EN
  logic        dec_q, dec_d;
`endif

  // Rotation amount applied when moving into round r.
  function automatic logic [1:0] shift_amt(input logic [3:0] r);
    return (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
    return (s == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

`ifdef DESCRYPT_KS_DECRYPT_EN
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
    return (s == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction
`endif

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) begin
      o[47 - i] = cd[56 - PC2_TAB[i]];
    end
    return o;
  endfunction

  // Next-state logic: load on handshake in IDLE, advance one round per
  // accepted subkey in RUN. The subkey register is refreshed from the
  // rotated halves except on the final accept, so the last subkey holds.
  always_comb begin
    state_d  = state_q;
    c_half_d = c_half_q;
    d_half_d = d_half_q;
    subkey_d = subkey_q;
    round_d  = round_q;
    iter_d   = iter_q;
`ifdef DESCRYPT_KS_DECRYPT_EN
    dec_d    = dec_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ks.cd_valid) begin
          c_half_d = rotl28(ks.cd_in[55:28], 2'd1);
          d_half_d = rotl28(ks.cd_in[27:0], 2'd1);
`ifdef DESCRYPT_KS_DECRYPT_EN
          dec_d = ks.dec;
          if (ks.dec) begin
            // Unrotated halves give K16 (total shift of a pass is 28).
            c_half_d = ks.cd_in[55:28];
            d_half_d = ks.cd_in[27:0];
          end
`endif
          subkey_d = pc2({c_half_d, d_half_d});
          round_d  = 4'd0;
          iter_d   = 6'd0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (ks.subkey_ready) begin
          // At round 15 the rotate-by-1 lands back on rotl(original,1),
          // so the next pass starts without a reload.
          c_half_d = rotl28(c_half_q, shift_amt(round_q + 4'd1));
          d_half_d = rotl28(d_half_q, shift_amt(round_q + 4'd1));
`ifdef DESCRYPT_KS_DECRYPT_EN
          if (dec_q) begin
            c_half_d = rotr28(c_half_q, shift_amt(4'd15 - round_q));
            d_half_d = rotr28(d_half_q, shift_amt(4'd15 - round_q));
          end
`endif
          round_d = round_q + 4'd1;
          if (round_q == 4'd15) begin
            iter_d = iter_q + 6'd1;
          end
          if (round_q == 4'd15 && iter_q == ITER_LAST) begin
            state_d = S_IDLE;
            iter_d  = 6'd0;
          end else begin
            subkey_d = pc2({c_half_d, d_half_d});
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      c_half_q <= '0;
      d_half_q <= '0;
      subkey_q <= '0;
      round_q  <= '0;
      iter_q   <= '0;
`ifdef DESCRYPT_KS_DECRYPT_EN
      dec_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      c_half_q <= c_half_d;
      d_half_q <= d_half_d;
      subkey_q <= subkey_d;
      round_q  <= round_d;
      iter_q   <= iter_d;
`ifdef DESCRYPT_KS_DECRYPT_EN
      dec_q    <= dec_d;
`endif
    end
  end

  assign ks.cd_ready     = (state_q == S_IDLE);
  assign ks.subkey_valid = (state_q == S_RUN);
  assign ks.subkey       = subkey_q;
  assign ks.round        = round_q;
  assign ks.last_round   = (state_q == S_RUN) && (round_q == 4'd15);
  assign ks.last_iter    = (state_q == S_RUN) && (iter_q == ITER_LAST);

endmodule

// File: tb/tb_descrypt_key_sched.sv
// Self-checking bench for descrypt_key_sched: table of known FIPS subkeys
// plus randomized keys/stalls checked against a closed-form schedule model.
module tb_descrypt_key_sched;

  localparam int ITER   = 25;
  localparam int TOTAL  = ITER * 16;
  localparam int BUDGET = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  descrypt_key_sched_if ks_if ();

  descrypt_key_sched #(.ITERATIONS(ITER)) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .ks    (ks_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] cap_sub [TOTAL];
  logic        cap_lr  [TOTAL];
  logic        cap_li  [TOTAL];

  typedef struct {
    int          idx;
    logic [47:0] sub;
    logic        lr;
    logic        li;
  } vec_t;

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Subkey K(k+1): both halves rotated left by the cumulative shift count.
  function automatic logic [47:0] model_key(input logic [55:0] cd, input int k);
    logic [27:0] c;
    logic [27:0] d;
    logic [55:0] cat;
    logic [47:0] o;
    int s;
    s = 0;
    for (int j = 0; j <= k; j++) s += (j == 0 || j == 1 || j == 8 || j == 15) ? 1 : 2;
    s = s % 28;
    c = cd[55:28];
    d = cd[27:0];
    if (s != 0) begin
      c = (c << s) | (c >> (28 - s));
      d = (d << s) | (d >> (28 - s));
    end
    cat = {c, d};
    o = '0;
    for (int i = 0; i < 48; i++) o[47 - i] = cat[56 - PC2[i]];
    return o;
  endfunction

  function automatic logic [63:0] pack(input logic rdy, input logic [47:0] sub,
                                       input logic [3:0] rnd, input logic lr, input logic li);
    return {9'd0, rdy, sub, rnd, lr, li};
  endfunction

  function automatic logic [55:0] rnd56();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[55:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Loads cd (unless already presented) and consumes the whole ITER x 16
  // sequence. mode 0: ready tied high; mode 1: random stalls.
  task automatic run_key(input logic [55:0] cd, input bit dec, input int mode,
                         input bit pulses, input bit b2b, input logic [55:0] nxt,
                         input int rst_at, input bit preloaded);
    int n;
    int cycles;
    int valid_cnt;
    int k;
    int kk;
    bit prev_stall;
    logic [63:0] prev_pack;
    logic [63:0] cur;
    logic rdy;
    if (!preloaded) begin
      @(negedge clk);
      ks_if.cd_in    = cd;
      ks_if.cd_valid = 1'b1;
`ifdef DESCRYPT_KS_DECRYPT_EN
      ks_if.dec      = dec;
`endif
    end
    chk("load_ready", 64'(ks_if.cd_ready), 64'd1);
    @(negedge clk);
    ks_if.cd_valid = 1'b0;
    ks_if.cd_in    = rnd56();
    n = 0;
    cycles = 0;
    valid_cnt = 0;
    prev_stall = 1'b0;
    prev_pack = '0;
    while (n < TOTAL && cycles < BUDGET) begin
      if (cycles > 0) @(negedge clk);
      cycles++;
      cur = pack(ks_if.cd_ready, ks_if.subkey, ks_if.round, ks_if.last_round, ks_if.last_iter);
      if (prev_stall) chk($sformatf("stall_hold%0d", n), cur, prev_pack);
      if (ks_if.subkey_valid) begin
        valid_cnt++;
        k  = n % 16;
        kk = dec ? 15 - k : k;
        chk($sformatf("beat%0d", n), cur,
            pack(1'b0, model_key(cd, kk), 4'(k), k == 15, (n / 16) == ITER - 1));
      end else begin
        chk($sformatf("valid%0d", n), 64'(ks_if.subkey_valid), 64'd1);
      end
      if (rst_at == n) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(ks_if.cd_ready), 64'd1);
        chk("rst_valid", 64'(ks_if.subkey_valid), 64'd0);
        chk("rst_outs", pack(1'b0, ks_if.subkey, ks_if.round, ks_if.last_round, ks_if.last_iter),
            64'd0);
        #2;
        rst_n = 1'b1;
        ks_if.subkey_ready = 1'b1;
        ks_if.cd_valid = 1'b0;
        return;
      end
      rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ks_if.subkey_ready = rdy;
      if (n == TOTAL - 1) begin
        ks_if.cd_valid = b2b;
        if (b2b) ks_if.cd_in = nxt;
      end else if (pulses) begin
        ks_if.cd_valid = 1'($urandom_range(0, 1));
        ks_if.cd_in    = rnd56();
`ifdef DESCRYPT_KS_DECRYPT_EN
        ks_if.dec      = 1'($urandom_range(0, 1));
`endif
      end
      prev_stall = ks_if.subkey_valid && !rdy;
      prev_pack  = cur;
      if (rdy && ks_if.subkey_valid) begin
        cap_sub[n] = ks_if.subkey;
        cap_lr[n]  = ks_if.last_round;
        cap_li[n]  = ks_if.last_iter;
        n++;
      end
    end
    if (n < TOTAL) begin
      chk("timeout", 64'(n), 64'(TOTAL));
    end
    @(negedge clk);
    chk("end_ready", 64'(ks_if.cd_ready), 64'd1);
    chk("end_valid", 64'(ks_if.subkey_valid), 64'd0);
    chk("end_hold", 64'(ks_if.subkey), 64'(model_key(cd, dec ? 0 : 15)));
    if (mode == 0) chk("valid_cycles", 64'(valid_cnt), 64'(TOTAL));
    ks_if.subkey_ready = 1'b1;
  endtask

  initial begin
    vec_t enc_tab [8];
    logic [55:0] fips;
    logic [55:0] ka;
    logic [55:0] kb;
    enc_tab[0] = '{0,   48'h1B02EFFC7072, 1'b0, 1'b0};
    enc_tab[1] = '{1,   48'h79AED9DBC9E5, 1'b0, 1'b0};
    enc_tab[2] = '{2,   48'h55FC8A42CF99, 1'b0, 1'b0};
    enc_tab[3] = '{15,  48'hCB3D8B0E17F5, 1'b1, 1'b0};
    enc_tab[4] = '{16,  48'h1B02EFFC7072, 1'b0, 1'b0};
    enc_tab[5] = '{383, 48'hCB3D8B0E17F5, 1'b1, 1'b0};
    enc_tab[6] = '{384, 48'h1B02EFFC7072, 1'b0, 1'b1};
    enc_tab[7] = '{399, 48'hCB3D8B0E17F5, 1'b1, 1'b1};
    fips = 56'hF0CCAAF556678F;

    ks_if.cd_in        = '0;
    ks_if.cd_valid     = 1'b0;
    ks_if.subkey_ready = 1'b1;
`ifdef DESCRYPT_KS_DECRYPT_EN
    ks_if.dec          = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ks_if.cd_ready), 64'd1);
    chk("reset_valid", 64'(ks_if.subkey_valid), 64'd0);
    chk("reset_outs", pack(1'b0, ks_if.subkey, ks_if.round, ks_if.last_round, ks_if.last_iter),
        64'd0);
    rst_n = 1'b1;

    // FIPS key, ready tied high, then known-answer table.
    run_key(fips, 1'b0, 0, 1'b0, 1'b0, '0, -1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tab_sub%0d", enc_tab[i].idx), 64'(cap_sub[enc_tab[i].idx]), 64'(enc_tab[i].sub));
      chk($sformatf("tab_flags%0d", enc_tab[i].idx),
          64'({cap_lr[enc_tab[i].idx], cap_li[enc_tab[i].idx]}),
          64'({enc_tab[i].lr, enc_tab[i].li}));
    end

    // Random key with random stalls and cd_valid pulses during RUN.
    run_key(rnd56(), 1'b0, 1, 1'b1, 1'b0, '0, -1, 1'b0);

    // Reset at round 7 of pass 3, then a fresh key must start at K1, iter 0.
    run_key(rnd56(), 1'b0, 0, 1'b0, 1'b0, '0, 3 * 16 + 7, 1'b0);
    run_key(rnd56(), 1'b0, 0, 1'b0, 1'b0, '0, -1, 1'b0);

    // Back-to-back: second cd_valid held across the final accept.
    ka = rnd56();
    kb = rnd56();
    run_key(ka, 1'b0, 0, 1'b0, 1'b1, kb, -1, 1'b0);
    run_key(kb, 1'b0, 0, 1'b0, 1'b0, '0, -1, 1'b1);

`ifdef DESCRYPT_KS_DECRYPT_EN
    run_key(fips, 1'b1, 0, 1'b0, 1'b0, '0, -1, 1'b0);
    chk("dec_first", 64'(cap_sub[0]), 64'(48'hCB3D8B0E17F5));
    chk("dec_16th", 64'(cap_sub[15]), 64'(48'h1B02EFFC7072));
    chk("dec_17th", 64'(cap_sub[16]), 64'(48'hCB3D8B0E17F5));
    run_key(rnd56(), 1'b1, 1, 1'b1, 1'b0, '0, -1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
